tone_generator: RTL
===================

TONE_GENERATOR -- requirements
Module: tone_generator

Interface
REQ-001 SHALL have port CLK100MHZ, input, 1 bit: the single 100 MHz system clock; all logic is on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports dig_3, dig_2, dig_1, dig_0, input, 4 bits each: BCD frequency in Hz (thousands, hundreds, tens, ones).
REQ-004 SHALL have port load, input, 1 bit: capture strobe for the dig_* inputs.
REQ-005 SHALL have port vol, input, 4 bits: amplitude step, 0..15.
REQ-006 SHALL have port busy, output, 1 bit: high while a load is being processed.
REQ-007 SHALL have port err, output, 1 bit: high if the last load held a non-BCD digit.
REQ-008 SHALL have port freq_out, output, 14 bits: binary frequency in Hz currently in use.
REQ-009 SHALL have port audio_out, output, 12 bits: unsigned DAC sample, midscale 2048.
REQ-010 SHALL have port sample_valid, output, 1 bit: one-cycle pulse on each audio_out update.

Function
REQ-011 SHALL generate a sample tick every 5000 clocks (20 kHz) using a divider that counts 0..4999, with the tick on count 4999.
REQ-012 SHALL run a load FSM with the states IDLE, CHECK, CONV and APPLY; busy SHALL be 1 in every state except IDLE.
REQ-013 SHALL, in IDLE with load=1, register the four digits and go to CHECK; load SHALL be ignored in every other state.
REQ-014 SHALL, in CHECK, return to IDLE with err=1 and freq_out unchanged if any digit is >9; otherwise it SHALL clear err, clear the accumulator and go to CONV.
REQ-015 SHALL spend exactly 4 cycles in CONV, most significant digit first, computing acc = acc*10 + digit each cycle (14-bit result, maximum 9999).
REQ-016 SHALL, in APPLY, set freq_out to acc, reset the phase to 0 and return to IDLE; busy is therefore high for exactly 6 cycles on a valid load and 1 cycle on an invalid one.
REQ-017 SHALL keep a phase accumulator of at least 15 bits, range 0..19999; on each tick phase_next = phase + freq_out, minus 20000 if the sum is >=20000.
REQ-018 SHALL, on each tick with freq_out != 0, set audio_out to HIGH = 2048 + vol*127 when phase_next < 10000, else to LOW = 2048 - vol*127; the phase SHALL take phase_next.
REQ-019 SHALL, on each tick with freq_out = 0, set audio_out to 2048 and hold the phase at 0.
REQ-020 SHALL assert sample_valid for the same single cycle in which audio_out updates, which is the clock edge at the tick.
REQ-021 SHALL, when APPLY coincides with a tick, let APPLY win: the phase goes to 0, audio_out keeps its value and sample_valid still pulses.
REQ-022 SHALL take the vol value sampled at each tick; vol changes between ticks SHALL have no effect until the next tick.
REQ-023 SHALL keep the waveform compatible with the team's zero-crossing frequency measurement: the 2048 midscale lies between LOW and HIGH for every vol >= 1.

Reset
REQ-024 SHALL, with reset=1 at a clock edge, set: state IDLE, busy 0, err 0, freq_out 0, audio_out 2048, sample_valid 0, phase 0, divider 0, accumulator 0.
REQ-025 SHALL abort any load in progress on reset, leaving freq_out at 0 and no APPLY taking place.
REQ-026 SHALL give reset priority over load and over the tick.

Structure
REQ-027 SHALL put SAMPLE_DIV=5000, SAMPLE_RATE=20000, HALF_RATE=10000, MIDSCALE=2048, VOL_STEP=127 and the FSM state encoding in the shared package tone_pkg.
REQ-028 SHALL put the 4-cycle sequential conversion in one sub-module, bcd4_to_bin, with start and done handshake; the divider, phase logic and output logic stay in tone_generator.

Verification
REQ-029 SHALL cover: load 1,0,0,0, vol=15 -> busy for 6 cycles, freq_out=1000, then a repeating pattern of 10 samples at 3953 and 10 samples at 143, with sample_valid every 5000 clocks.
REQ-030 SHALL cover: load 0,4,4,0, vol=8 -> over 20000 ticks exactly 440 LOW-to-HIGH transitions, with levels 3064 and 1032.
REQ-031 SHALL cover: dig_1=4'hA on load -> err=1, busy high for 1 cycle, freq_out and the waveform unchanged; a following valid load -> err=0.
REQ-032 SHALL cover: load 0,0,0,0 -> freq_out=0 and audio_out constant 2048 on every tick.
REQ-033 SHALL cover: a second load pulsed during CONV -> ignored, freq_out equal to the first load's value.
REQ-034 SHALL cover: reset asserted in the 2nd CONV cycle -> next cycle busy=0, freq_out=0, audio_out=2048, and the next tick 5000 clocks after reset is released.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants, load-FSM encoding and BCD helpers for the tone generator.
package tone_pkg;

    localparam int unsigned SAMPLE_DIV  = 5000;
    localparam int unsigned SAMPLE_RATE = 20000;
    localparam int unsigned HALF_RATE   = 10000;
    localparam int unsigned MIDSCALE    = 2048;
    localparam int unsigned VOL_STEP    = 127;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned FREQ_W  = 14;
    localparam int unsigned PHASE_W = 15;
    localparam int unsigned SUM_W   = PHASE_W + 1;
    localparam int unsigned DIV_W   = 13;
    localparam int unsigned AUDIO_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_CONV  = 2'd2,
        ST_APPLY = 2'd3
    } load_state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] d3;
        logic [DIGIT_W-1:0] d2;
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d0;
    } bcd_word_t;

    function automatic logic has_non_bcd(input bcd_word_t w);
        return (w.d3 > 4'd9) || (w.d2 > 4'd9) || (w.d1 > 4'd9) || (w.d0 > 4'd9);
    endfunction

endpackage

// File: rtl/bcd4_to_bin.sv
// Sequential 4-digit BCD to binary: one digit per cycle, most significant first.
module bcd4_to_bin
    import tone_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  bcd_word_t         digits_i,
    output logic [FREQ_W-1:0] acc_o,
    output logic              done_c
);

    localparam logic [FREQ_W-1:0] TEN = FREQ_W'(10);

    logic [1:0]         cnt_q;
    logic               active_q;
    logic [FREQ_W-1:0]  acc_q;
    logic [DIGIT_W-1:0] digit_c;

    always_comb begin
        digit_c = digits_i.d0;
        case (cnt_q)
            2'd0:    digit_c = digits_i.d3;
            2'd1:    digit_c = digits_i.d2;
            2'd2:    digit_c = digits_i.d1;
            default: digit_c = digits_i.d0;
        endcase
    end

    // Asserted during the cycle whose edge performs the final step.
    assign done_c = active_q && (cnt_q == 2'd3);
    assign acc_o  = acc_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= 2'd0;
            active_q <= 1'b0;
            acc_q    <= '0;
        end else if (start_i) begin
            cnt_q    <= 2'd0;
            active_q <= 1'b1;
            acc_q    <= '0;
        end else if (active_q) begin
            acc_q <= (acc_q * TEN) + FREQ_W'(digit_c);
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone generator: BCD frequency load, 20 kHz sample tick, phase accumulator.
module tone_generator
    import tone_pkg::*;
(
    input  logic               CLK100MHZ,
    input  logic               reset,
    input  logic [3:0]         dig_3,
    input  logic [3:0]         dig_2,
    input  logic [3:0]         dig_1,
    input  logic [3:0]         dig_0,
    input  logic               load,
    input  logic [3:0]         vol,
    output logic               busy,
    output logic               err,
    output logic [13:0]        freq_out,
    output logic [11:0]        audio_out,
    output logic               sample_valid
);

    load_state_e        state_q;
    logic               busy_q;
    logic               err_q;
    logic [FREQ_W-1:0]  freq_q;
    bcd_word_t          digits_q;
    logic [DIV_W-1:0]   div_q;
    logic [PHASE_W-1:0] phase_q;
    logic [AUDIO_W-1:0] audio_q;
    logic               valid_q;

    logic               conv_start_c;
    logic               conv_done_c;
    logic [FREQ_W-1:0]  conv_acc;
    logic               tick_c;
    logic [SUM_W-1:0]   phase_sum_c;
    logic [PHASE_W-1:0] phase_next_c;
    logic [AUDIO_W-1:0] vol_scaled_c;
    logic [AUDIO_W-1:0] level_hi_c;
    logic [AUDIO_W-1:0] level_lo_c;

    assign busy         = busy_q;
    assign err          = err_q;
    assign freq_out     = freq_q;
    assign audio_out    = audio_q;
    assign sample_valid = valid_q;

    assign conv_start_c = (state_q == ST_CHECK) && !has_non_bcd(digits_q);

    bcd4_to_bin u_bcd4_to_bin (
        .clk_i    (CLK100MHZ),
        .reset_i  (reset),
        .start_i  (conv_start_c),
        .digits_i (digits_q),
        .acc_o    (conv_acc),
        .done_c   (conv_done_c)
    );

    // Load FSM: capture, validate, convert, apply.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            freq_q   <= '0;
            digits_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        digits_q <= {dig_3, dig_2, dig_1, dig_0};
                        state_q  <= ST_CHECK;
                        busy_q   <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (has_non_bcd(digits_q)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        err_q   <= 1'b0;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done_c) begin
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    freq_q  <= conv_acc;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tick_c       = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign phase_sum_c  = SUM_W'(phase_q) + SUM_W'(freq_q);
    assign phase_next_c = (phase_sum_c >= SUM_W'(SAMPLE_RATE))
                        ? PHASE_W'(phase_sum_c - SUM_W'(SAMPLE_RATE))
                        : PHASE_W'(phase_sum_c);
    assign vol_scaled_c = AUDIO_W'(vol) * AUDIO_W'(VOL_STEP);
    assign level_hi_c   = AUDIO_W'(MIDSCALE) + vol_scaled_c;
    assign level_lo_c   = AUDIO_W'(MIDSCALE) - vol_scaled_c;

    // Sample divider, phase accumulator and DAC output; a concurrent APPLY wins over the tick.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            div_q   <= '0;
            phase_q <= '0;
            audio_q <= AUDIO_W'(MIDSCALE);
            valid_q <= 1'b0;
        end else begin
            div_q   <= tick_c ? '0 : div_q + DIV_W'(1);
            valid_q <= tick_c;
            if (state_q == ST_APPLY) begin
                phase_q <= '0;
            end else if (tick_c) begin
                if (freq_q == '0) begin
                    audio_q <= AUDIO_W'(MIDSCALE);
                    phase_q <= '0;
                end else begin
                    audio_q <= (phase_next_c < PHASE_W'(HALF_RATE)) ? level_hi_c : level_lo_c;
                    phase_q <= phase_next_c;
                end
            end
        end
    end

endmodule
